adbg_or1k_cpu_stall_ctrl: RTL and testbench
===========================================

# adbg_or1k_cpu_stall_ctrl

CPU-side responder of the OR1K debug stall/reset interface. Consumes the stall and reset requests driven by the debug status register, which are already synchronized into the CPU clock domain. Freezes and drains the core pipeline, reports halted state and stop cause, and generates the breakpoint pulse (trap, watchpoint, single-step) that the status register latches as `bp_i`. Sits in the CPU clock domain, between the debug unit and the OR1K pipeline control.

## Interface
Parameters:
- `DRAIN_TIMEOUT`, 64: maximum cycles spent in DRAIN before halt is forced; legal range ≥ 2.
- `RST_CYCLES`, 4: minimum `core_rst_o` pulse width in cycles; legal range ≥ 1.

Ports:
- `cpu_clk_i`  in  1  CPU clock; the only clock.
- `rst_ni`  in  1  Asynchronous, active-low reset.
- `dbg_stall_i`  in  1  Stall request from the status register (`cpu_stall_o`).
- `dbg_rst_i`  in  1  Core reset request from the status register (`cpu_rst_o`).
- `step_en_i`  in  1  Single-step mode enable; quasi-static debug SPR bit.
- `trap_i`  in  1  `l.trap` retired this cycle.
- `wp_hit_i`  in  1  Watchpoint match this cycle.
- `insn_retire_i`  in  1  One instruction retired this cycle.
- `pipe_idle_i`  in  1  Pipeline has no in-flight instructions.
- `pipe_freeze_o`  out  1  Hold fetch/issue.
- `core_rst_o`  out  1  Core reset.
- `bp_o`  out  1  One-cycle breakpoint pulse to the status register `bp_i`.
- `halted_o`  out  1  Core frozen and drained.
- `stop_cause_o`  out  3  Stop cause: 0 none, 1 host, 2 trap, 3 watchpoint, 4 step.
- `drain_to_o`  out  1  Sticky flag: last halt was forced by drain timeout.

## Operation
- FSM states: RUN, DRAIN, HALT, CRST. All outputs are registered (Moore).
- Reset (`rst_ni`=0) forces:
  - state RUN;
  - `pipe_freeze_o`, `core_rst_o`, `bp_o`, `halted_o`, `drain_to_o` = 0;
  - `stop_cause_o` = 0;
  - counter = 0.
- RUN. Priority, highest first:
  - `dbg_rst_i` → CRST.
  - `trap_i` → DRAIN, cause 2, `bp_o` pulse.
  - `wp_hit_i` → DRAIN, cause 3, `bp_o` pulse.
  - `step_en_i & insn_retire_i` → DRAIN, cause 4, `bp_o` pulse.
  - `dbg_stall_i` → DRAIN, cause 1, no `bp_o`.
  - Entering DRAIN clears the counter.
- DRAIN:
  - Outputs: `pipe_freeze_o`=1; counter increments each cycle.
  - `dbg_rst_i` → CRST.
  - Else `pipe_idle_i` → HALT.
  - Else counter == `DRAIN_TIMEOUT`-1 → HALT with `drain_to_o`=1.
  - A drop of `dbg_stall_i` during DRAIN is ignored; DRAIN always completes.
- HALT:
  - Outputs: `pipe_freeze_o`=1, `halted_o`=1.
  - `dbg_rst_i` → CRST.
  - Else `dbg_stall_i`=0 → RUN; `stop_cause_o` and `drain_to_o` cleared on entry to RUN.
- CRST:
  - Outputs: `core_rst_o`=1, `pipe_freeze_o`=1, `halted_o`=0.
  - `stop_cause_o` and `drain_to_o` are cleared on entry.
  - Counter counts from 0, saturating at `RST_CYCLES`.
  - Exit to RUN when counter ≥ `RST_CYCLES`-1 and `dbg_rst_i`=0.
- `trap_i`, `wp_hit_i`, `insn_retire_i` are ignored outside RUN. `bp_o` is emitted only on a RUN→DRAIN transition.
- Single-step: after leaving HALT with `step_en_i`=1, the first retirement in RUN stops the core again with cause 4.
- Counter: one shared counter, width `$clog2(max(DRAIN_TIMEOUT,RST_CYCLES))+1`; no wrap.

## Timing
- Event sampled at edge N:
  - state, `pipe_freeze_o`=1 and `bp_o`=1 valid in cycle N+1;
  - `bp_o` returns to 0 in cycle N+2.
- The status register turns `bp_o` into `dbg_stall_i`=1 combinationally in the same cycle, so `dbg_stall_i` is high before HALT is reached.
- `pipe_idle_i` high at edge M while in DRAIN → `halted_o`=1 in cycle M+1. Minimum RUN→HALT latency is 2 cycles.
- Timeout: `halted_o` rises exactly `DRAIN_TIMEOUT`+1 cycles after the triggering edge when `pipe_idle_i` stays 0.
- `dbg_stall_i` low at edge K in HALT → `pipe_freeze_o`=0 and `halted_o`=0 in cycle K+1.
- `core_rst_o` stays high for ≥ `RST_CYCLES` cycles, and until the cycle after `dbg_rst_i` is sampled low.
- Reset is asynchronous mid-operation: `core_rst_o` and all other outputs drop immediately, with no pulse-width guarantee.

## Test plan
- Host stall: `dbg_stall_i`=1 at edge 0, `pipe_idle_i`=1 at edge 3 → `pipe_freeze_o`=1 from cycle 1; `halted_o`=1 from cycle 4; `stop_cause_o`=1; `bp_o` never asserted. Drop `dbg_stall_i` → RUN next cycle, cause=0.
- Trap/watchpoint collision: `trap_i`=`wp_hit_i`=1 same cycle → exactly one `bp_o` pulse, `stop_cause_o`=2. Repeat with `wp_hit_i` alone → cause 3.
- Single-step: `step_en_i`=1, release HALT, `insn_retire_i` pulse → `bp_o` single pulse, cause 4, halt again. Verify one retirement per release across 3 iterations.
- Drain timeout (`DRAIN_TIMEOUT`=8): stall with `pipe_idle_i` held 0 → `halted_o` rises 9 cycles after the trigger, `drain_to_o`=1; cleared on resume.
- Core reset (`RST_CYCLES`=4): 1-cycle `dbg_rst_i` pulse in HALT → `core_rst_o` high exactly 4 cycles, `halted_o`=0, cause=0, then RUN. Long pulse of 10 cycles → `core_rst_o` tracks it, falling 1 cycle after release.
- Async reset asserted mid-DRAIN and mid-CRST → all outputs 0 immediately. Deassert → RUN with no spurious `bp_o`.

Source files
------------

// File: rtl/adbg_or1k_cpu_stall_ctrl_if.sv
// Signal bundle between the debug stall/reset logic and the OR1K pipeline
// control. The stall controller sits on the slave side; a driver or the
// surrounding debug/pipeline glue sits on the master side.
interface adbg_or1k_cpu_stall_ctrl_if;

    // Requests from the debug status register, already in the CPU domain
    logic       dbg_stall_i;
    logic       dbg_rst_i;
    logic       step_en_i;

    // Pipeline events and status
    logic       trap_i;
    logic       wp_hit_i;
    logic       insn_retire_i;
    logic       pipe_idle_i;

    // Controls and status back to pipeline and debug unit
    logic       pipe_freeze_o;
    logic       core_rst_o;
    logic       bp_o;
    logic       halted_o;
    logic [2:0] stop_cause_o;
    logic       drain_to_o;

    modport slave (
        input  dbg_stall_i,
        input  dbg_rst_i,
        input  step_en_i,
        input  trap_i,
        input  wp_hit_i,
        input  insn_retire_i,
        input  pipe_idle_i,
        output pipe_freeze_o,
        output core_rst_o,
        output bp_o,
        output halted_o,
        output stop_cause_o,
        output drain_to_o
    );

    modport master (
        output dbg_stall_i,
        output dbg_rst_i,
        output step_en_i,
        output trap_i,
        output wp_hit_i,
        output insn_retire_i,
        output pipe_idle_i,
        input  pipe_freeze_o,
        input  core_rst_o,
        input  bp_o,
        input  halted_o,
        input  stop_cause_o,
        input  drain_to_o
    );

endinterface

// File: rtl/adbg_or1k_cpu_stall_ctrl.sv
// CPU-side responder of the OR1K debug stall/reset handshake. Freezes and
// drains the pipeline on a host stall or a debug event (trap, watchpoint,
// single-step), reports halted state and stop cause, emits the one-cycle
// breakpoint pulse, and stretches debug core resets to a minimum width.
// All outputs are registered; they reflect the state entered at the last edge.
module adbg_or1k_cpu_stall_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter int unsigned RST_CYCLES    = 4
) (
    input  logic                             cpu_clk_i,
    input  logic                             rst_ni,
    adbg_or1k_cpu_stall_ctrl_if.slave        ctrl
);

    // One counter is shared by DRAIN (timeout) and CRST (pulse width), so it
    // is sized for the larger of the two limits plus one bit of headroom.
    localparam int unsigned MAX_CNT = (DRAIN_TIMEOUT > RST_CYCLES) ? DRAIN_TIMEOUT : RST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_SAT    = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2,
        ST_CRST  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_HOST = 3'd1,
        CAUSE_TRAP = 3'd2,
        CAUSE_WP   = 3'd3,
        CAUSE_STEP = 3'd4
    } cause_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    cause_e           r_cause;
    logic             r_drain_to;
    logic             r_freeze;
    logic             r_core_rst;
    logic             r_bp;
    logic             r_halted;

    state_e           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    cause_e           w_cause_next;
    logic             w_drain_to_next;
    logic             w_freeze_next;
    logic             w_core_rst_next;
    logic             w_bp_next;
    logic             w_halted_next;

    logic             w_stop_req;
    cause_e           w_stop_cause;
    logic             w_stop_bp;
    logic             w_cnt_inc;
    logic             w_enter_drain;

    // Prioritise the reasons to leave RUN: debug events beat a plain host stall.
    always_comb begin
        w_stop_req   = 1'b0;
        w_stop_cause = CAUSE_NONE;
        w_stop_bp    = 1'b0;
        if (ctrl.trap_i) begin
            w_stop_req   = 1'b1;
            w_stop_cause = CAUSE_TRAP;
            w_stop_bp    = 1'b1;
        end else if (ctrl.wp_hit_i) begin
            w_stop_req   = 1'b1;
            w_stop_cause = CAUSE_WP;
            w_stop_bp    = 1'b1;
        end else if (ctrl.step_en_i && ctrl.insn_retire_i) begin
            w_stop_req   = 1'b1;
            w_stop_cause = CAUSE_STEP;
            w_stop_bp    = 1'b1;
        end else if (ctrl.dbg_stall_i) begin
            w_stop_req   = 1'b1;
            w_stop_cause = CAUSE_HOST;
            w_stop_bp    = 1'b0;
        end
    end

    // Next state, counter and sticky status; a debug core reset wins from any
    // non-reset state and wipes the stop cause and timeout flag.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_cause_next    = r_cause;
        w_drain_to_next = r_drain_to;
        w_cnt_inc       = 1'b0;

        if (r_state != ST_CRST && ctrl.dbg_rst_i) begin
            w_state_next    = ST_CRST;
            w_cnt_next      = CNT_ZERO;
            w_cause_next    = CAUSE_NONE;
            w_drain_to_next = 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_stop_req) begin
                        w_state_next = ST_DRAIN;
                        w_cnt_next   = CNT_ZERO;
                        w_cause_next = w_stop_cause;
                    end
                end
                ST_DRAIN: begin
                    // A drop of the host stall is deliberately ignored here:
                    // the drain always runs to completion.
                    if (ctrl.pipe_idle_i) begin
                        w_state_next = ST_HALT;
                    end else if (r_cnt == DRAIN_LAST) begin
                        w_state_next    = ST_HALT;
                        w_drain_to_next = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (!ctrl.dbg_stall_i) begin
                        w_state_next    = ST_RUN;
                        w_cause_next    = CAUSE_NONE;
                        w_drain_to_next = 1'b0;
                    end
                end
                ST_CRST: begin
                    if (r_cnt >= RST_LAST && !ctrl.dbg_rst_i) begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = CNT_ZERO;
                    end else if (r_cnt < RST_SAT) begin
                        w_cnt_inc = 1'b1;
                    end
                end
                default: begin
                    w_state_next    = ST_RUN;
                    w_cnt_next      = CNT_ZERO;
                    w_cause_next    = CAUSE_NONE;
                    w_drain_to_next = 1'b0;
                end
            endcase
        end

        if (w_cnt_inc) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    // Moore outputs derived from the state being entered, so the registered
    // copies line up with that state in the following cycle.
    always_comb begin
        w_freeze_next   = 1'b0;
        w_core_rst_next = 1'b0;
        w_halted_next   = 1'b0;
        w_enter_drain   = (r_state == ST_RUN) && (w_state_next == ST_DRAIN);
        w_bp_next       = w_enter_drain && w_stop_bp;
        unique case (w_state_next)
            ST_RUN: begin
                w_freeze_next = 1'b0;
            end
            ST_DRAIN: begin
                w_freeze_next = 1'b1;
            end
            ST_HALT: begin
                w_freeze_next = 1'b1;
                w_halted_next = 1'b1;
            end
            ST_CRST: begin
                w_freeze_next   = 1'b1;
                w_core_rst_next = 1'b1;
            end
            default: begin
                w_freeze_next = 1'b0;
            end
        endcase
    end

    // State, shared counter and sticky stop status.
    always_ff @(posedge cpu_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_RUN;
            r_cnt      <= CNT_ZERO;
            r_cause    <= CAUSE_NONE;
            r_drain_to <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cause    <= w_cause_next;
            r_drain_to <= w_drain_to_next;
        end
    end

    // Registered pipeline controls and status flags.
    always_ff @(posedge cpu_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_freeze   <= 1'b0;
            r_core_rst <= 1'b0;
            r_bp       <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_freeze   <= w_freeze_next;
            r_core_rst <= w_core_rst_next;
            r_bp       <= w_bp_next;
            r_halted   <= w_halted_next;
        end
    end

    assign ctrl.pipe_freeze_o = r_freeze;
    assign ctrl.core_rst_o    = r_core_rst;
    assign ctrl.bp_o          = r_bp;
    assign ctrl.halted_o      = r_halted;
    assign ctrl.stop_cause_o  = r_cause;
    assign ctrl.drain_to_o    = r_drain_to;

endmodule

// File: tb/tb_adbg_or1k_cpu_stall_ctrl.sv
// Randomized bench for the OR1K CPU stall/reset responder. A behavioural
// model tracks the controller's mode with cycle timestamps and predicts every
// output each cycle; the stall input mimics the status register, which turns
// a breakpoint pulse into a held stall request.
module tb_adbg_or1k_cpu_stall_ctrl;

    localparam int DT = 8;
    localparam int RC = 4;

    localparam int MODE_RUN   = 0;
    localparam int MODE_DRAIN = 1;
    localparam int MODE_HALT  = 2;
    localparam int MODE_CRST  = 3;

    logic clk = 1'b0;
    logic rstN;

    adbg_or1k_cpu_stall_ctrl_if ctrlIf();

    adbg_or1k_cpu_stall_ctrl #(
        .DRAIN_TIMEOUT(DT),
        .RST_CYCLES   (RC)
    ) dut (
        .cpu_clk_i(clk),
        .rst_ni   (rstN),
        .ctrl     (ctrlIf.slave)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;
    int cycle     = 0;

    // Reference model state: mode, cycle at which it was entered, and status
    int         mMode;
    int         mEnter;
    logic       mBp;
    logic [2:0] mCause;
    logic       mDto;

    // Episode knobs and stimulus memory
    int   idlePct;
    int   evtPct;
    int   rstPct;
    logic stepEn;
    logic hostStall;
    logic bpHold;
    int   rstLeft;

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("pipe_freeze", 8'(ctrlIf.pipe_freeze_o), 8'(mMode != MODE_RUN));
        checkOutput("core_rst",    8'(ctrlIf.core_rst_o),    8'(mMode == MODE_CRST));
        checkOutput("halted",      8'(ctrlIf.halted_o),      8'(mMode == MODE_HALT));
        checkOutput("bp",          8'(ctrlIf.bp_o),          8'(mBp));
        checkOutput("stop_cause",  8'(ctrlIf.stop_cause_o),  8'(mCause));
        checkOutput("drain_to",    8'(ctrlIf.drain_to_o),    8'(mDto));
    endtask

    task automatic modelReset();
        mMode  = MODE_RUN;
        mEnter = cycle;
        mBp    = 1'b0;
        mCause = 3'd0;
        mDto   = 1'b0;
    endtask

    task automatic enterDrain(input logic [2:0] cause, input logic withBp);
        mMode  = MODE_DRAIN;
        mEnter = cycle + 1;
        mCause = cause;
        mBp    = withBp;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic modelEdge();
        logic wasRun;
        wasRun = (mMode == MODE_RUN);
        mBp    = 1'b0;
        if (mMode != MODE_CRST && ctrlIf.dbg_rst_i) begin
            mMode  = MODE_CRST;
            mEnter = cycle + 1;
            mCause = 3'd0;
            mDto   = 1'b0;
        end else if (wasRun) begin
            if (ctrlIf.trap_i)                                  enterDrain(3'd2, 1'b1);
            else if (ctrlIf.wp_hit_i)                           enterDrain(3'd3, 1'b1);
            else if (ctrlIf.step_en_i && ctrlIf.insn_retire_i)  enterDrain(3'd4, 1'b1);
            else if (ctrlIf.dbg_stall_i)                        enterDrain(3'd1, 1'b0);
        end else if (mMode == MODE_DRAIN) begin
            if (ctrlIf.pipe_idle_i) begin
                mMode = MODE_HALT;
            end else if (cycle - mEnter >= DT - 1) begin
                mMode = MODE_HALT;
                mDto  = 1'b1;
            end
        end else if (mMode == MODE_HALT) begin
            if (!ctrlIf.dbg_stall_i) begin
                mMode  = MODE_RUN;
                mCause = 3'd0;
                mDto   = 1'b0;
            end
        end else begin
            if (cycle - mEnter >= RC - 1 && !ctrlIf.dbg_rst_i) begin
                mMode = MODE_RUN;
            end
        end
        cycle++;
    endtask

    task automatic clearInputs();
        ctrlIf.dbg_stall_i   = 1'b0;
        ctrlIf.dbg_rst_i     = 1'b0;
        ctrlIf.step_en_i     = 1'b0;
        ctrlIf.trap_i        = 1'b0;
        ctrlIf.wp_hit_i      = 1'b0;
        ctrlIf.insn_retire_i = 1'b0;
        ctrlIf.pipe_idle_i   = 1'b0;
        hostStall = 1'b0;
        bpHold    = 1'b0;
        rstLeft   = 0;
    endtask

    // Random inputs for the coming edge; stall follows host plus any latched bp.
    task automatic applyStimulus();
        if (hostStall) begin
            if (chance(25)) hostStall = 1'b0;
        end else begin
            if (chance(6)) hostStall = 1'b1;
        end
        if (mBp) bpHold = 1'b1;
        else if (mMode == MODE_HALT && chance(40)) bpHold = 1'b0;

        if (rstLeft == 0 && chance(rstPct)) begin
            rstLeft = chance(50) ? 1 : int'($urandom_range(12, 2));
        end
        ctrlIf.dbg_rst_i = (rstLeft > 0);
        if (rstLeft > 0) rstLeft--;

        ctrlIf.dbg_stall_i   = hostStall | bpHold;
        ctrlIf.step_en_i     = stepEn;
        ctrlIf.trap_i        = chance(evtPct / 2);
        ctrlIf.wp_hit_i      = chance(evtPct / 2);
        ctrlIf.insn_retire_i = chance(50);
        ctrlIf.pipe_idle_i   = chance(idlePct);
    endtask

    // Pull reset mid-cycle, confirm outputs drop at once, release after an edge.
    task automatic asyncReset();
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkAll();
        clearInputs();
        @(posedge clk);
        #2;
        rstN = 1'b1;
    endtask

    initial begin
        clearInputs();
        stepEn  = 1'b0;
        idlePct = 0;
        evtPct  = 0;
        rstPct  = 0;
        rstN    = 1'b0;
        modelReset();
        #3;
        checkAll();
        #9;
        rstN = 1'b1;

        for (int ep = 0; ep < 60; ep++) begin
            case ($urandom_range(2))
                0:       idlePct = 0;
                1:       idlePct = 25;
                default: idlePct = 70;
            endcase
            evtPct = int'($urandom_range(30));
            rstPct = int'($urandom_range(6));
            stepEn = (ep % 3 == 1) ? 1'b1 : 1'(($urandom_range(1)));
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                checkAll();
                if ((mMode == MODE_DRAIN || mMode == MODE_CRST) && chance(4)) begin
                    asyncReset();
                end else begin
                    applyStimulus();
                    modelEdge();
                end
            end
        end

        @(negedge clk);
        checkAll();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
